rename_free_list: RTL

Physical-register free list for the out-of-order rename stage. Supplies the `dst` physical register (`preg_addr_t`) for up to two renamed instructions per cycle. Takes back stale physical registers released at retirement. On a pipeline flush, restores every speculatively allocated register in one cycle by rewinding to the committed head pointer. Sits between the rename stage, which consumes `alloc_preg` into `renaming_data_t.dst`, and the retire logic, which frees the previous mapping of each committed destination.

---
 rtl/rename_free_list.sv | 93 +++++++++
 1 files changed

// File: rtl/rename_free_list.sv
// Physical-register free list for the rename stage.
// Circular array of free pregs with a speculative head, a committed head and
// a tail. Pointers carry one extra wrap bit so full and empty are distinct.
// Up to two grants and two returns per cycle; flush rewinds head to the
// committed head in a single cycle.
module rename_free_list #(
  parameter int PREG_NUM = 64,
  parameter int CREG_NUM = 32,
  parameter int DEPTH    = PREG_NUM - CREG_NUM,
  localparam int PW      = $clog2(PREG_NUM),
  localparam int IW      = $clog2(DEPTH),
  localparam int CW      = IW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    alloc_req,
  input  logic          alloc_en,
  output logic          alloc_ok,
  output logic [PW-1:0] alloc_preg [2],
  input  logic [1:0]    retire_valid,
  input  logic [PW-1:0] retire_old_preg [2],
  input  logic          flush,
  output logic [CW-1:0] free_count
);

  logic [PW-1:0] r_entries [DEPTH];
  logic [CW-1:0] r_head;
  logic [CW-1:0] r_commit_head;
  logic [CW-1:0] r_tail;

  logic [CW-1:0] w_alloc_cnt;
  logic [CW-1:0] w_ret_cnt;
  logic [CW-1:0] w_commit_next;
  logic [CW-1:0] w_tail_next;
  logic [CW-1:0] w_head_next;
  logic [IW-1:0] w_rd_idx0;
  logic [IW-1:0] w_rd_idx1;
  logic [IW-1:0] w_wr_idx0;
  logic [IW-1:0] w_wr_idx1;
  logic          w_alloc_fire;

  // Grant side: counts, occupancy and lane-packed read of the head entries.
  // alloc_ok uses the pre-retire count so same-cycle returns never bypass.
  always_comb begin
    w_alloc_cnt   = {{(CW-1){1'b0}}, alloc_req[0]} + {{(CW-1){1'b0}}, alloc_req[1]};
    w_ret_cnt     = {{(CW-1){1'b0}}, retire_valid[0]} + {{(CW-1){1'b0}}, retire_valid[1]};
    free_count    = r_tail - r_head;
    alloc_ok      = (free_count >= w_alloc_cnt);
    w_rd_idx0     = r_head[IW-1:0];
    w_rd_idx1     = alloc_req[0] ? (w_rd_idx0 + 1'b1) : w_rd_idx0;
    alloc_preg[0] = r_entries[w_rd_idx0];
    alloc_preg[1] = r_entries[w_rd_idx1];
  end

  // Pointer next-state: retire always advances tail and commit head; flush
  // rewinds head to the post-retire commit head and suppresses allocation.
  always_comb begin
    w_wr_idx0     = r_tail[IW-1:0];
    w_wr_idx1     = retire_valid[0] ? (w_wr_idx0 + 1'b1) : w_wr_idx0;
    w_commit_next = r_commit_head + w_ret_cnt;
    w_tail_next   = r_tail + w_ret_cnt;
    w_alloc_fire  = alloc_en & alloc_ok & ~flush;
    w_head_next   = r_head;
    if (flush) begin
      w_head_next = w_commit_next;
    end else if (w_alloc_fire) begin
      w_head_next = r_head + w_alloc_cnt;
    end
  end

  // State update: reset seeds the list with the pregs above the arch set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= PW'(CREG_NUM + i);
      end
      r_head        <= '0;
      r_commit_head <= '0;
      r_tail        <= CW'(DEPTH);
    end else begin
      if (retire_valid[0]) begin
        r_entries[w_wr_idx0] <= retire_old_preg[0];
      end
      if (retire_valid[1]) begin
        r_entries[w_wr_idx1] <= retire_old_preg[1];
      end
      r_head        <= w_head_next;
      r_commit_head <= w_commit_next;
      r_tail        <= w_tail_next;
    end
  end

endmodule
